// File: rtl/reg_param_2r_2w_bypass_if.sv
// Bundles the register file's two read ports, two write ports,
// the clear pulse and the collision flag.
// The master drives reads and writes. The slave, which is the register file, returns read results.
interface reg_param_2r_2w_bypass_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [WIDTH-1:0]  rd0_data;
    logic              rd0_valid;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [WIDTH-1:0]  rd1_data;
    logic              rd1_valid;
    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [WIDTH-1:0]  wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [WIDTH-1:0]  wr1_data;
    logic              clear_all;
    logic              wr_collide;

    modport master (
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output clear_all,
        input  rd0_data, rd0_valid, rd1_data, rd1_valid, wr_collide
    );

    modport slave (
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  clear_all,
        output rd0_data, rd0_valid, rd1_data, rd1_valid, wr_collide
    );
endinterface

// File: rtl/reg_param_2r_2w_bypass.sv
// Parametrised DEPTH x WIDTH register file.
// It has two registered read ports, two write ports and a valid bit per entry.
// A one-cycle flash clear invalidates all entries.
// Reads are write-first: a same-cycle write to the address being read is returned.
// Write port 1 has priority when both write ports target the same entry.
module reg_param_2r_2w_bypass #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 40,
    parameter int ADDR_W = 6
) (
    input  logic clk,
    input  logic rst,
    reg_param_2r_2w_bypass_if.slave bus
);

    // DEPTH may equal 2**ADDR_W, so the limit needs one extra bit.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic              wr0_hit;
    logic              wr1_hit;
    logic              collide;

    logic              rd_en      [2];
    logic [ADDR_W-1:0] rd_addr    [2];
    logic [WIDTH-1:0]  rd_data_d  [2];
    logic              rd_valid_d [2];
    logic [WIDTH-1:0]  rd_data_q  [2];
    logic              rd_valid_q [2];
    logic              collide_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    assign rd_en[0]   = bus.rd0_en;
    assign rd_en[1]   = bus.rd1_en;
    assign rd_addr[0] = bus.rd0_addr;
    assign rd_addr[1] = bus.rd1_addr;

    // Qualify each write port: it must be enabled and target an existing entry.
    always_comb begin
        wr0_hit = bus.wr0_en && in_range(bus.wr0_addr);
        wr1_hit = bus.wr1_en && in_range(bus.wr1_addr);
        collide = wr0_hit && wr1_hit && (bus.wr0_addr == bus.wr1_addr);
    end

    // Entry storage and valid bits. Write port 1 wins a shared address.
    // A write overrides a clear that lands on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
                vld[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr1_hit && bus.wr1_addr == ADDR_W'(i)) begin
                    mem[i] <= bus.wr1_data;
                    vld[i] <= 1'b1;
                end else if (wr0_hit && bus.wr0_addr == ADDR_W'(i)) begin
                    mem[i] <= bus.wr0_data;
                    vld[i] <= 1'b1;
                end else if (bus.clear_all) begin
                    vld[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd

        // Each port returns the entry as it will look after this edge:
        // same-cycle write data first, otherwise stored data.
        // A concurrent clear drops the stored valid bit.
        always_comb begin
            rd_data_d[p]  = '0;
            rd_valid_d[p] = 1'b0;
            if (in_range(rd_addr[p])) begin
                if (wr1_hit && bus.wr1_addr == rd_addr[p]) begin
                    rd_data_d[p]  = bus.wr1_data;
                    rd_valid_d[p] = 1'b1;
                end else if (wr0_hit && bus.wr0_addr == rd_addr[p]) begin
                    rd_data_d[p]  = bus.wr0_data;
                    rd_valid_d[p] = 1'b1;
                end else begin
                    rd_data_d[p]  = mem[rd_addr[p]];
                    rd_valid_d[p] = vld[rd_addr[p]] && !bus.clear_all;
                end
            end
        end

        // Register the read result. Outputs hold while the port is idle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_data_q[p]  <= '0;
                rd_valid_q[p] <= 1'b0;
            end else if (rd_en[p]) begin
                rd_data_q[p]  <= rd_data_d[p];
                rd_valid_q[p] <= rd_valid_d[p];
            end
        end
    end

    // Flag a same-address double write for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collide_q <= 1'b0;
        end else begin
            collide_q <= collide;
        end
    end

    assign bus.rd0_data   = rd_data_q[0];
    assign bus.rd0_valid  = rd_valid_q[0];
    assign bus.rd1_data   = rd_data_q[1];
    assign bus.rd1_valid  = rd_valid_q[1];
    assign bus.wr_collide = collide_q;

endmodule

// File: tb/tb_reg_param_2r_2w_bypass.sv
module tb_reg_param_2r_2w_bypass;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    reg_param_2r_2w_bypass_if #(.WIDTH(32), .ADDR_W(6)) bus ();

    reg_param_2r_2w_bypass #(.WIDTH(32), .DEPTH(40), .ADDR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rd0_en    = 1'b0;
        bus.rd1_en    = 1'b0;
        bus.wr0_en    = 1'b0;
        bus.wr1_en    = 1'b0;
        bus.clear_all = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle();
        bus.rd0_addr = '0;
        bus.rd1_addr = '0;
        bus.wr0_addr = '0;
        bus.wr1_addr = '0;
        bus.wr0_data = '0;
        bus.wr1_data = '0;
        #3;
        check("reset_rd0_data",  bus.rd0_data, 32'h0);
        check("reset_rd0_valid", 32'(bus.rd0_valid), 32'h0);
        check("reset_rd1_data",  bus.rd1_data, 32'h0);
        check("reset_collide",   32'(bus.wr_collide), 32'h0);
        #9 rst = 1'b1;

        // 1: read of an unwritten entry
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd5;
        tick();
        check("t1_rd0_data",  bus.rd0_data, 32'h0);
        check("t1_rd0_valid", 32'(bus.rd0_valid), 32'h0);
        check("t1_collide",   32'(bus.wr_collide), 32'h0);

        // 2: write then read back on port 1
        bus.wr0_en = 1'b1; bus.wr0_addr = 6'd3; bus.wr0_data = 32'hDEADBEEF;
        tick();
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd3;
        tick();
        check("t2_rd1_data",  bus.rd1_data, 32'hDEADBEEF);
        check("t2_rd1_valid", 32'(bus.rd1_valid), 32'h1);

        // 3: colliding writes with bypass read
        bus.wr0_en = 1'b1; bus.wr0_addr = 6'd7; bus.wr0_data = 32'h11;
        bus.wr1_en = 1'b1; bus.wr1_addr = 6'd7; bus.wr1_data = 32'h22;
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd7;
        tick();
        check("t3_rd0_bypass",  bus.rd0_data, 32'h22);
        check("t3_rd0_valid",   32'(bus.rd0_valid), 32'h1);
        check("t3_collide_set", 32'(bus.wr_collide), 32'h1);
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd7;
        tick();
        check("t3_collide_clr", 32'(bus.wr_collide), 32'h0);
        check("t3_rd1_stored",  bus.rd1_data, 32'h22);
        check("t3_rd0_hold",    bus.rd0_data, 32'h22);

        // bypass from write port 0 alone; writes to different addresses do not collide
        bus.wr0_en = 1'b1; bus.wr0_addr = 6'd12; bus.wr0_data = 32'hA5;
        bus.wr1_en = 1'b1; bus.wr1_addr = 6'd13; bus.wr1_data = 32'h5A;
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd12;
        tick();
        check("wr0_bypass_data", bus.rd1_data, 32'hA5);
        check("no_collide_diff", 32'(bus.wr_collide), 32'h0);

        // 4: fill all entries, then clear with a concurrent write
        for (int i = 0; i < 20; i++) begin
            bus.wr0_en = 1'b1; bus.wr0_addr = 6'(i);      bus.wr0_data = 32'h100 + 32'(i);
            bus.wr1_en = 1'b1; bus.wr1_addr = 6'(i + 20); bus.wr1_data = 32'h100 + 32'(i + 20);
            tick();
        end
        bus.clear_all = 1'b1;
        bus.wr1_en = 1'b1; bus.wr1_addr = 6'd9; bus.wr1_data = 32'h55;
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd9;
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd10;
        tick();
        check("t4_clr_byp_data",  bus.rd0_data, 32'h55);
        check("t4_clr_byp_valid", 32'(bus.rd0_valid), 32'h1);
        check("t4_clr_rd_data",   bus.rd1_data, 32'h10A);
        check("t4_clr_rd_valid",  32'(bus.rd1_valid), 32'h0);
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd9;
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd10;
        tick();
        check("t4_a9_data",   bus.rd0_data, 32'h55);
        check("t4_a9_valid",  32'(bus.rd0_valid), 32'h1);
        check("t4_a10_data",  bus.rd1_data, 32'h10A);
        check("t4_a10_valid", 32'(bus.rd1_valid), 32'h0);

        // same address on both ports
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd9;
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd9;
        tick();
        check("same_addr_rd1", bus.rd1_data, 32'h55);

        // 5: out-of-range write and reads
        bus.wr0_en = 1'b1; bus.wr0_addr = 6'd40; bus.wr0_data = 32'hFF;
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd40;
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd39;
        tick();
        check("t5_oor_data",   bus.rd0_data, 32'h0);
        check("t5_oor_valid",  32'(bus.rd0_valid), 32'h0);
        check("t5_a39_data",   bus.rd1_data, 32'h127);
        check("t5_a39_valid",  32'(bus.rd1_valid), 32'h0);
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd0;
        bus.rd1_en = 1'b1; bus.rd1_addr = 6'd63;
        tick();
        check("t5_a0_data",     bus.rd0_data, 32'h100);
        check("t5_oor63_data",  bus.rd1_data, 32'h0);
        check("t5_oor63_valid", 32'(bus.rd1_valid), 32'h0);

        // 6: reset in the middle of a cycle
        bus.wr0_en = 1'b1; bus.wr0_addr = 6'd2; bus.wr0_data = 32'h77;
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd9;
        tick();
        check("t6_pre_rd0", bus.rd0_data, 32'h55);
        #3 rst = 1'b0;
        #1;
        check("t6_rst_rd0_data",  bus.rd0_data, 32'h0);
        check("t6_rst_rd0_valid", 32'(bus.rd0_valid), 32'h0);
        check("t6_rst_rd1_data",  bus.rd1_data, 32'h0);
        #2 rst = 1'b1;
        bus.rd0_en = 1'b1; bus.rd0_addr = 6'd2;
        tick();
        check("t6_a2_valid", 32'(bus.rd0_valid), 32'h0);
        check("t6_a2_data",  bus.rd0_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
